// File: rtl/organ_sequencer.sv
// Tone organ sequencer: manual switch passthrough or automatic Do..Do scale playback,
// plus the square-wave generator that turns the lookup table's half-period into audio.
module organ_sequencer #(
  parameter int NOTE_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int DUR_W       = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic        manual_en,
  input  logic [3:0]  sw,
  input  logic [31:0] div_in,
  output logic [3:0]  note_code,
  output logic [2:0]  note_idx,
  output logic        busy,
  output logic        audio_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [2:0]       idx;
  logic [DUR_W-1:0] dur;
  logic             rst_p0;

  logic [3:0]       code_p0;
  logic [31:0]      tone_cnt;
  logic             aud_q;
  logic             code_chg;
  logic [31:0]      cnt_eff;
  logic             aud_eff;

  // Sequencer FSM; stop outranks start and any note/gap expiry in the same cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= 3'd0;
      dur   <= '0;
    end else if (stop) begin
      state <= IDLE;
      idx   <= 3'd0;
      dur   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= NOTE;
            idx   <= 3'd0;
            dur   <= '0;
          end
        end
        NOTE: begin
          if (dur == NOTE_LAST) begin
            state <= GAP;
            dur   <= '0;
          end else begin
            dur <= dur + DUR_W'(1);
          end
        end
        GAP: begin
          if (dur == GAP_LAST) begin
            dur <= '0;
            if (idx != 3'd7) begin
              idx   <= idx + 3'd1;
              state <= NOTE;
            end else if (loop_en) begin
              idx   <= 3'd0;
              state <= NOTE;
            end else begin
              idx   <= 3'd0;
              state <= IDLE;
            end
          end else begin
            dur <= dur + DUR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= 3'd0;
          dur   <= '0;
        end
      endcase
    end
  end

  // Blocks manual passthrough during the cycle that follows a sampled reset
  always_ff @(posedge clk) begin
    rst_p0 <= ~reset_n;
  end

  always_comb begin
    note_code = 4'b0000;
    case (state)
      IDLE:    note_code = (manual_en && !rst_p0) ? sw : 4'b0000;
      NOTE:    note_code = {idx, 1'b1};
      default: note_code = 4'b0000;
    endcase
  end

  assign busy     = (state != IDLE);
  assign note_idx = idx;

  // A code change restarts the tone phase from low in the very cycle it appears
  assign code_chg  = (note_code != code_p0);
  assign cnt_eff   = code_chg ? 32'd0 : tone_cnt;
  assign aud_eff   = code_chg ? 1'b0 : aud_q;
  assign audio_out = aud_q & ~code_chg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      code_p0  <= 4'b0000;
      tone_cnt <= 32'd0;
      aud_q    <= 1'b0;
    end else begin
      code_p0 <= note_code;
      if (div_in == 32'd0) begin
        tone_cnt <= 32'd0;
        aud_q    <= 1'b0;
      end else if (cnt_eff >= div_in - 32'd1) begin
        tone_cnt <= 32'd0;
        aud_q    <= ~aud_eff;
      end else begin
        tone_cnt <= cnt_eff + 32'd1;
        aud_q    <= aud_eff;
      end
    end
  end

endmodule

// File: tb/tb_organ_sequencer.sv
// Bench for organ_sequencer: directed scenarios followed by random stimulus, all checked
// against a scale-position reference model.
module tb_organ_sequencer;

  localparam int NC    = 8;
  localparam int GC    = 2;
  localparam int PER   = NC + GC;
  localparam int SCALE = 8 * PER;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic        manual_en;
  logic [3:0]  sw;
  logic [31:0] div_in;
  logic [3:0]  note_code;
  logic [2:0]  note_idx;
  logic        busy;
  logic        audio_out;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          play_m = 1'b0;
  int          t_m    = 0;
  bit          rst_m  = 1'b1;
  logic [3:0]  q_m    = 4'b0000;
  int          k_m    = 0;

  logic        busy_s;
  logic        audio_s;
  logic [3:0]  code_s;

  always #5 clk = ~clk;

  assign div_in = note_code[0] ? 32'd3 : 32'd0;

  organ_sequencer #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC), .DUR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .manual_en(manual_en), .sw(sw), .div_in(div_in), .note_code(note_code),
    .note_idx(note_idx), .busy(busy), .audio_out(audio_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic cyc();
    logic [3:0] c;
    logic [2:0] ix;
    logic       a;
    int         kk;
    int         d;
    @(negedge clk);
    ix = play_m ? 3'(t_m / PER) : 3'd0;
    if (play_m) c = ((t_m % PER) < NC) ? {ix, 1'b1} : 4'b0000;
    else        c = (manual_en && !rst_m) ? sw : 4'b0000;
    kk = (c != q_m) ? 0 : k_m;
    d  = c[0] ? 3 : 0;
    a  = (d != 0) ? (((kk / d) % 2) == 1) : 1'b0;
    check("note_code", 32'(note_code), 32'(c));
    check("note_idx", 32'(note_idx), 32'(ix));
    check("busy", 32'(busy), 32'(play_m));
    check("audio_out", 32'(audio_out), 32'(a));
    busy_s  = busy;
    audio_s = audio_out;
    code_s  = note_code;
    @(posedge clk);
    if (!reset_n) begin
      play_m = 1'b0;
      t_m    = 0;
      q_m    = 4'b0000;
      k_m    = 0;
    end else begin
      q_m = c;
      k_m = kk + 1;
      if (stop) begin
        play_m = 1'b0;
        t_m    = 0;
      end else if (!play_m) begin
        if (start) begin
          play_m = 1'b1;
          t_m    = 0;
        end
      end else begin
        t_m++;
        if (t_m == SCALE) begin
          t_m = 0;
          if (!loop_en) play_m = 1'b0;
        end
      end
    end
    rst_m = !reset_n;
    #1;
  endtask

  initial begin
    int         bcnt;
    int         drops;
    logic [7:0] aud8;
    logic [11:0] aud12;

    reset_n   = 1'b0;
    start     = 1'b1;
    stop      = 1'b0;
    loop_en   = 1'b0;
    manual_en = 1'b1;
    sw        = 4'b0001;

    // reset held with start and manual passthrough requested
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_code", 32'(code_s), 32'd0);
      check("rst_audio", 32'(audio_s), 32'd0);
    end
    reset_n = 1'b1;
    cyc();
    cyc();
    check("rel_code", 32'(code_s), 32'd1);
    start = 1'b0;
    stop  = 1'b1;
    cyc();
    stop      = 1'b0;
    manual_en = 1'b0;
    cyc();

    // single scale, no loop
    start = 1'b1;
    cyc();
    start = 1'b0;
    bcnt  = 0;
    aud8  = '0;
    for (int i = 0; i < SCALE + 20; i++) begin
      cyc();
      if (busy_s) bcnt++;
      if (i < NC) aud8[7 - i] = audio_s;
    end
    check("scale_busy_cycles", 32'(bcnt), 32'(SCALE));
    check("first_note_wave", 32'(aud8), 32'h1C);
    check("scale_end_idx", 32'(note_idx), 32'd0);

    // looping playback
    loop_en = 1'b1;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    drops = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (!busy_s) drops++;
      if (i == SCALE) check("wrap_code", 32'(code_s), 32'd1);
    end
    check("loop_busy_drops", 32'(drops), 32'd0);
    loop_en = 1'b0;
    stop    = 1'b1;
    cyc();
    stop = 1'b0;

    // stop at cycle 4 of note 2 together with start
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2 * PER + 3; i++) cyc();
    stop  = 1'b1;
    start = 1'b1;
    cyc();
    stop  = 1'b0;
    start = 1'b0;
    cyc();
    check("stop_busy", 32'(busy_s), 32'd0);
    check("stop_code", 32'(code_s), 32'd0);
    check("stop_audio", 32'(audio_s), 32'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("restart_code", 32'(code_s), 32'd1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // manual passthrough
    manual_en = 1'b1;
    sw        = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      cyc();
      aud12[11 - i] = audio_s;
    end
    check("manual_wave", 32'(aud12), 32'h1C7);
    sw = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("manual_silent", 32'(audio_s), 32'd0);
    end

    // auto play ignores sw and extra starts
    start = 1'b1;
    cyc();
    for (int i = 0; i < 40; i++) begin
      start = ($urandom_range(0, 3) == 0);
      sw    = 4'($urandom);
      cyc();
    end
    start = 1'b0;
    stop  = 1'b1;
    cyc();
    stop = 1'b0;

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      reset_n   = ($urandom_range(0, 255) != 0);
      stop      = ($urandom_range(0, 79) == 0);
      start     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 31) == 0) manual_en = ~manual_en;
      if ($urandom_range(0, 7) == 0) sw = 4'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
